// File: rtl/alu_arbiter_seq.sv
// Round-robin sequencer that shares one combinational ALU between two requesters.
// Operands are registered, held for ALU_LAT cycles, and the result is returned with Z/N flags.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | arbitrate; combinational ready to at most one requester
//  S_ISSUE | operand regs drive the ALU; settle counter counts down
//  S_RESP  | registered result presented until the consumer takes it
module alu_arbiter_seq #(
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned W       = 16
) (
   input  logic         clk,
   input  logic         rst_n,

   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [2:0]   req0_mode,

   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [2:0]   req1_mode,

   output logic [W-1:0] alu_in1,
   output logic [W-1:0] alu_in2,
   output logic [2:0]   alu_mode,
   input  logic [W-1:0] alu_out,

   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [W-1:0] rsp_data,
   output logic         rsp_zero,
   output logic         rsp_neg
);

   localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           prio_q, prio_d;
   logic [W-1:0]   op_a_q, op_a_d;
   logic [W-1:0]   op_b_q, op_b_d;
   logic [2:0]     op_mode_q, op_mode_d;
   logic           op_id_q, op_id_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_id_q, rsp_id_d;
   logic [W-1:0]   rsp_data_q, rsp_data_d;
   logic           rsp_zero_q, rsp_zero_d;
   logic           rsp_neg_q, rsp_neg_d;
   logic           grant0, grant1;

   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_mode_d   = op_mode_q;
      op_id_d     = op_id_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_zero_d  = rsp_zero_q;
      rsp_neg_d   = rsp_neg_q;
      grant0      = 1'b0;
      grant1      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // prio_q == 0 favours req0; the loser of a tie wins the next tie
            grant0 = req0_valid && (!prio_q || !req1_valid);
            grant1 = req1_valid && ( prio_q || !req0_valid);
            if (grant0 || grant1) begin
               op_a_d    = grant1 ? req1_a    : req0_a;
               op_b_d    = grant1 ? req1_b    : req0_b;
               op_mode_d = grant1 ? req1_mode : req0_mode;
               op_id_d   = grant1;
               prio_d    = ~grant1;
               cnt_d     = LAT_LOAD;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (cnt_q == 4'd0) begin
               rsp_data_d  = alu_out;
               rsp_zero_d  = (alu_out == '0);
               rsp_neg_d   = alu_out[W-1];
               rsp_id_d    = op_id_q;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         prio_q      <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_mode_q   <= 3'd0;
         op_id_q     <= 1'b0;
         cnt_q       <= 4'd0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_neg_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_mode_q   <= op_mode_d;
         op_id_q     <= op_id_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_zero_q  <= rsp_zero_d;
         rsp_neg_q   <= rsp_neg_d;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   // Operand regs feed the ALU permanently; they only change on an accept edge
   assign alu_in1    = op_a_q;
   assign alu_in2    = op_b_q;
   assign alu_mode   = op_mode_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_neg    = rsp_neg_q;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Bench for alu_arbiter_seq: one instance with ALU_LAT=1 and one with ALU_LAT=3 on shared inputs,
// each closing its loop through a behavioural ALU; expected responses flow through a queue.
module tb_alu_arbiter_seq;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         r0_valid, r1_valid, rsp_ready;
   logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
   logic [2:0]   r0_mode, r1_mode;

   logic         r0_ready, r1_ready, rsp_valid, rsp_id, rsp_zero, rsp_neg;
   logic [W-1:0] alu_in1, alu_in2, alu_out, rsp_data;
   logic [2:0]   alu_mode;

   logic         r0_ready_l3, r1_ready_l3, rsp_valid_l3, rsp_id_l3, rsp_zero_l3, rsp_neg_l3;
   logic [W-1:0] alu_in1_l3, alu_in2_l3, alu_out_l3, rsp_data_l3;
   logic [2:0]   alu_mode_l3;

   typedef struct packed {
      logic         id;
      logic [W-1:0] data;
      logic         z;
      logic         n;
   } exp_t;

   typedef struct packed {
      logic         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [2:0]   mode;
      logic [W-1:0] res;
      logic         z;
      logic         n;
   } op_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic exp_ptr = 1'b0;

   function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] m);
      case (m)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a >> b;
         3'd3:    return a << b;
         3'd4:    return a & b;
         3'd5:    return a | b;
         3'd6:    return ~a;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_out    = alu_f(alu_in1, alu_in2, alu_mode);
   assign alu_out_l3 = alu_f(alu_in1_l3, alu_in2_l3, alu_mode_l3);

   alu_arbiter_seq #(.ALU_LAT(1), .W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r0_valid), .req0_ready(r0_ready), .req0_a(r0_a), .req0_b(r0_b), .req0_mode(r0_mode),
      .req1_valid(r1_valid), .req1_ready(r1_ready), .req1_a(r1_a), .req1_b(r1_b), .req1_mode(r1_mode),
      .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_mode(alu_mode), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
   );

   alu_arbiter_seq #(.ALU_LAT(3), .W(W)) dut_l3 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(r0_valid), .req0_ready(r0_ready_l3), .req0_a(r0_a), .req0_b(r0_b), .req0_mode(r0_mode),
      .req1_valid(r1_valid), .req1_ready(r1_ready_l3), .req1_a(r1_a), .req1_b(r1_b), .req1_mode(r1_mode),
      .alu_in1(alu_in1_l3), .alu_in2(alu_in2_l3), .alu_mode(alu_mode_l3), .alu_out(alu_out_l3),
      .rsp_valid(rsp_valid_l3), .rsp_ready(rsp_ready), .rsp_id(rsp_id_l3), .rsp_data(rsp_data_l3),
      .rsp_zero(rsp_zero_l3), .rsp_neg(rsp_neg_l3)
   );

   task automatic test_reset();
      r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
      r0_a = '0; r0_b = '0; r0_mode = 3'd0; r1_a = '0; r1_b = '0; r1_mode = 3'd0;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({r0_ready, r1_ready, rsp_valid, rsp_id, rsp_zero, rsp_neg} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 000000", {r0_ready, r1_ready, rsp_valid, rsp_id, rsp_zero, rsp_neg});
      end
      n_tests++;
      if ({rsp_data, alu_in1, alu_in2, alu_mode} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: rsp_data=%h in1=%h in2=%h mode=%0d want all 0", rsp_data, alu_in1, alu_in2, alu_mode);
      end
      n_tests++;
      if ({rsp_valid_l3, rsp_data_l3, alu_in1_l3, alu_mode_l3} !== '0) begin
         n_fail++;
         $display("FAIL reset_l3: rsp_valid=%b rsp_data=%h in1=%h want 0", rsp_valid_l3, rsp_data_l3, alu_in1_l3);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({r0_ready, r1_ready, rsp_valid, rsp_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b%b rsp_valid=%b rsp_data=%h want 0", r0_ready, r1_ready, rsp_valid, rsp_data);
      end
      exp_ptr = 1'b0;
   endtask

   task automatic test_single_ops();
      op_t  tbl[8];
      exp_t e;
      tbl[0] = '{1'b0, 16'd200,  16'd300,  3'd0, 16'd500,  1'b0, 1'b0};
      tbl[1] = '{1'b1, 16'd5,    16'd7,    3'd1, 16'hFFFE, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 16'h00F0, 16'd15,   3'd3, 16'h0000, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 16'h8001, 16'd1,    3'd2, 16'h4000, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 16'hAAAA, 16'h1234, 3'd6, 16'h5555, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 16'h0F0F, 16'h00FF, 3'd4, 16'h000F, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 16'h0F0F, 16'hF000, 3'd5, 16'hFF0F, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 16'hFFFF, 16'hFFFF, 3'd7, 16'h0000, 1'b1, 1'b0};
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (!tbl[i].id) begin
            r0_valid = 1'b1; r0_a = tbl[i].a; r0_b = tbl[i].b; r0_mode = tbl[i].mode;
         end else begin
            r1_valid = 1'b1; r1_a = tbl[i].a; r1_b = tbl[i].b; r1_mode = tbl[i].mode;
         end
         sb.push_back('{tbl[i].id, tbl[i].res, tbl[i].z, tbl[i].n});
         #1;
         n_tests++;
         if ({r0_ready, r1_ready} !== (tbl[i].id ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL single_ready op%0d: got %b%b want id %0d only", i, r0_ready, r1_ready, tbl[i].id);
         end
         @(negedge clk);
         r0_valid = 1'b0; r1_valid = 1'b0;
         exp_ptr = ~tbl[i].id;
         n_tests++;
         if ({rsp_valid, r0_ready, r1_ready, alu_in1, alu_in2, alu_mode} !== {3'b000, tbl[i].a, tbl[i].b, tbl[i].mode}) begin
            n_fail++;
            $display("FAIL single_issue op%0d: rsp_valid=%b in1=%h in2=%h mode=%0d want 0 %h %h %0d",
                     i, rsp_valid, alu_in1, alu_in2, alu_mode, tbl[i].a, tbl[i].b, tbl[i].mode);
         end
         @(negedge clk);
         n_tests++;
         if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency op%0d: rsp_valid=%b want 1", i, rsp_valid);
         end else begin
            e = sb.pop_front();
            if ({rsp_id, rsp_data, rsp_zero, rsp_neg} !== e) begin
               n_fail++;
               $display("FAIL single_rsp op%0d: id=%b data=%h z=%b n=%b want id=%b data=%h z=%b n=%b",
                        i, rsp_id, rsp_data, rsp_zero, rsp_neg, e.id, e.data, e.z, e.n);
            end
         end
         @(negedge clk);
         n_tests++;
         if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done op%0d: rsp_valid=%b want 0", i, rsp_valid);
         end
      end
   endtask

   task automatic test_alternate();
      int   i0 = 0, i1 = 0, nrsp = 0, cyc = 0;
      bit   g0, g1;
      exp_t e;
      logic [W-1:0] sum;
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      r0_valid = 1'b1; r0_a = 16'h1000; r0_b = 16'd7; r0_mode = 3'd0;
      r1_valid = 1'b1; r1_a = 16'hF000; r1_b = 16'd7; r1_mode = 3'd0;
      while (nrsp < 8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid && rsp_ready) begin
            nrsp++;
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL alt_rsp: unexpected response id=%b data=%h", rsp_id, rsp_data);
            end else begin
               e = sb.pop_front();
               if ({rsp_id, rsp_data, rsp_zero, rsp_neg} !== e) begin
                  n_fail++;
                  $display("FAIL alt_rsp #%0d: id=%b data=%h z=%b n=%b want id=%b data=%h z=%b n=%b",
                           nrsp, rsp_id, rsp_data, rsp_zero, rsp_neg, e.id, e.data, e.z, e.n);
               end
            end
         end
         g0 = r0_ready && r0_valid;
         g1 = r1_ready && r1_valid;
         if (g0 || g1) begin
            sum = exp_ptr ? (r1_a + r1_b) : (r0_a + r0_b);
            sb.push_back('{exp_ptr, sum, sum == '0, sum[W-1]});
            n_tests++;
            if ((g0 && g1) || (g1 !== exp_ptr)) begin
               n_fail++;
               $display("FAIL alt_grant: got %b%b want requester %0d", g0, g1, exp_ptr);
            end
            exp_ptr = ~exp_ptr;
         end
         @(posedge clk); #1;
         if (g0) begin
            i0++;
            if (i0 == 4) r0_valid = 1'b0;
            else begin r0_a = 16'h1000 + 16'(i0 * 16'h0111); r0_b = 16'(i0 * 3 + 7); end
         end
         if (g1) begin
            i1++;
            if (i1 == 4) r1_valid = 1'b0;
            else begin r1_a = 16'hF000 + 16'(i1 * 16'h0801); r1_b = 16'(i1 * 3 + 7); end
         end
      end
      n_tests++;
      if (nrsp != 8 || i0 != 4 || i1 != 4) begin
         n_fail++;
         $display("FAIL alt_count: rsp=%0d grants=%0d/%0d want 8 4/4", nrsp, i0, i1);
      end
      r0_valid = 1'b0; r1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      exp_t e;
      @(negedge clk);
      rsp_ready = 1'b0;
      r0_valid = 1'b1; r0_a = 16'h1234; r0_b = 16'h00FF; r0_mode = 3'd7;
      sb.push_back('{1'b0, 16'h12CB, 1'b0, 1'b0});
      #1;
      n_tests++;
      if (r0_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_accept: r0_ready=%b want 1", r0_ready);
      end
      @(negedge clk);
      exp_ptr = 1'b1;
      r0_valid = 1'b0;
      r1_valid = 1'b1; r1_a = 16'hFFFF; r1_b = 16'h8000; r1_mode = 3'd4;
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_latency: rsp_valid=%b want 1", rsp_valid);
         e = '0;
      end else begin
         e = sb.pop_front();
      end
      for (int k = 0; k < 6; k++) begin
         n_tests++;
         if ({rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_neg, r0_ready, r1_ready} !== {1'b1, e, 2'b00}) begin
            n_fail++;
            $display("FAIL bp_hold cyc%0d: valid=%b id=%b data=%h z=%b n=%b rdy=%b%b want 1 %b %h %b %b 00",
                     k, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_neg, r0_ready, r1_ready, e.id, e.data, e.z, e.n);
         end
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      sb.push_back('{1'b1, 16'h8000, 1'b0, 1'b1});
      n_tests++;
      if ({rsp_valid, r1_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_regrant: rsp_valid=%b r1_ready=%b want 0 1", rsp_valid, r1_ready);
      end
      @(negedge clk);
      r1_valid = 1'b0;
      exp_ptr = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_second: rsp_valid=%b want 1", rsp_valid);
      end else begin
         e = sb.pop_front();
         if ({rsp_id, rsp_data, rsp_zero, rsp_neg} !== e) begin
            n_fail++;
            $display("FAIL bp_second: id=%b data=%h z=%b n=%b want id=%b data=%h z=%b n=%b",
                     rsp_id, rsp_data, rsp_zero, rsp_neg, e.id, e.data, e.z, e.n);
         end
      end
   endtask

   task automatic test_lat3();
      exp_t e;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_ptr = 1'b0;
      @(negedge clk);
      rsp_ready = 1'b1;
      r0_valid = 1'b1; r0_a = 16'hF000; r0_b = 16'd4; r0_mode = 3'd2;
      sb.push_back('{1'b0, 16'h0F00, 1'b0, 1'b0});
      #1;
      n_tests++;
      if (r0_ready_l3 !== 1'b1) begin
         n_fail++;
         $display("FAIL lat3_accept: r0_ready=%b want 1", r0_ready_l3);
      end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         r0_valid = 1'b0;
         n_tests++;
         if ({rsp_valid_l3, alu_in1_l3, alu_in2_l3, alu_mode_l3} !== {1'b0, 16'hF000, 16'd4, 3'd2}) begin
            n_fail++;
            $display("FAIL lat3_issue cyc%0d: valid=%b in1=%h in2=%h mode=%0d want 0 f000 0004 2",
                     k, rsp_valid_l3, alu_in1_l3, alu_in2_l3, alu_mode_l3);
         end
      end
      @(negedge clk);
      n_tests++;
      if (rsp_valid_l3 !== 1'b1) begin
         n_fail++;
         $display("FAIL lat3_latency: rsp_valid=%b want 1", rsp_valid_l3);
      end else begin
         e = sb.pop_front();
         if ({rsp_id_l3, rsp_data_l3, rsp_zero_l3, rsp_neg_l3, alu_in1_l3} !== {e, 16'hF000}) begin
            n_fail++;
            $display("FAIL lat3_rsp: id=%b data=%h z=%b n=%b in1=%h want id=%b data=%h z=%b n=%b in1=f000",
                     rsp_id_l3, rsp_data_l3, rsp_zero_l3, rsp_neg_l3, alu_in1_l3, e.id, e.data, e.z, e.n);
         end
      end
      repeat (2) @(negedge clk);
      exp_ptr = 1'b1;
   endtask

   task automatic test_reset_abort();
      exp_t e;
      bit   seen = 1'b0;
      int   cyc = 0;
      @(negedge clk);
      rsp_ready = 1'b1;
      r0_valid = 1'b1; r0_a = 16'd1; r0_b = 16'd2; r0_mode = 3'd0;
      @(negedge clk);
      r0_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if ({rsp_valid, rsp_data, alu_in1, alu_in2, rsp_valid_l3, alu_in1_l3, rsp_data_l3} !== '0) begin
         n_fail++;
         $display("FAIL abort_reset: valid=%b data=%h in1=%h in2=%h l3 valid=%b in1=%h data=%h want 0",
                  rsp_valid, rsp_data, alu_in1, alu_in2, rsp_valid_l3, alu_in1_l3, rsp_data_l3);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid || rsp_valid_l3) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL abort_norsp: rsp_valid seen after reset release, want none");
      end
      r0_valid = 1'b1; r0_a = 16'd3;  r0_b = 16'd4;  r0_mode = 3'd0;
      r1_valid = 1'b1; r1_a = 16'd10; r1_b = 16'd20; r1_mode = 3'd0;
      sb.push_back('{1'b0, 16'd7, 1'b0, 1'b0});
      #1;
      n_tests++;
      if ({r0_ready, r1_ready, r0_ready_l3, r1_ready_l3} !== 4'b1010) begin
         n_fail++;
         $display("FAIL abort_prio: ready=%b%b l3=%b%b want 10 10", r0_ready, r1_ready, r0_ready_l3, r1_ready_l3);
      end
      @(negedge clk);
      r0_valid = 1'b0; r1_valid = 1'b0;
      while (!rsp_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      n_tests++;
      if (!rsp_valid) begin
         n_fail++;
         $display("FAIL abort_next: rsp_valid=%b want 1 within 10 cycles", rsp_valid);
      end else begin
         e = sb.pop_front();
         if ({rsp_id, rsp_data, rsp_zero, rsp_neg} !== e) begin
            n_fail++;
            $display("FAIL abort_next: id=%b data=%h want id=%b data=%h", rsp_id, rsp_data, e.id, e.data);
         end
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_ops();
      test_alternate();
      test_backpressure();
      test_lat3();
      test_reset_abort();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_empty: %0d expected responses never seen, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
